// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared types and next-value function for the universal shift register
// Purpose : operating-mode and FSM-state enums plus the per-cycle operation
//           function used by the top level's next-state mux.
// Contents: USR_MAX_W  - widest register the shared function supports
//           usr_mode_t - HOLD, LOAD, CLEAR, SHL, SHR, ROL, ROR, ASR
//           usr_state_t- IDLE, RUN
//           is_burst_mode(), next_q()
package usr_pkg;

    localparam int USR_MAX_W = 64;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        SHL   = 3'd3,
        SHR   = 3'd4,
        ROL   = 3'd5,
        ROR   = 3'd6,
        ASR   = 3'd7
    } usr_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } usr_state_t;

    // Shift/rotate modes are the only ones that run as a counted burst.
    function automatic logic is_burst_mode(input usr_mode_t mode);
        return (mode >= SHL);
    endfunction

    // Operates on a zero-extended USR_MAX_W vector so one function serves any
    // register width; 'width' selects where the MSB lives. The result is masked
    // back to 'width' bits, so the upper bits are always zero.
    function automatic logic [USR_MAX_W-1:0] next_q(
        input usr_mode_t             mode,
        input logic [USR_MAX_W-1:0]  q,
        input logic                  sl_in,
        input logic                  sr_in,
        input int unsigned           width,
        input logic [USR_MAX_W-1:0]  d
    );
        logic [USR_MAX_W-1:0] mask;
        logic [USR_MAX_W-1:0] msb_bit;
        logic                 msb;
        logic [USR_MAX_W-1:0] r;
        mask    = (width >= USR_MAX_W) ? '1 : ((USR_MAX_W'(1) << width) - USR_MAX_W'(1));
        msb_bit = USR_MAX_W'(1) << (width - 1);
        msb     = |(q & msb_bit);
        case (mode)
            HOLD:    r = q;
            LOAD:    r = d;
            CLEAR:   r = '0;
            SHL:     r = (q << 1) | {{(USR_MAX_W-1){1'b0}}, sl_in};
            SHR:     r = (q >> 1) | (sr_in ? msb_bit : '0);
            ROL:     r = (q << 1) | {{(USR_MAX_W-1){1'b0}}, msb};
            ROR:     r = (q >> 1) | (q[0] ? msb_bit : '0);
            ASR:     r = (q >> 1) | (msb ? msb_bit : '0);
            default: r = q;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// rtl/universal_shift_register_if.sv - command/status bundle of the universal shift register
// Purpose : groups every non-clock/reset signal of the register.
// Signals : mode, d, sl_in, sr_in, start, count  (master -> slave)
//           q, so_msb, so_lsb, busy, done        (slave -> master)
// Modports: master (stimulus side), slave (register side)
interface universal_shift_register_if
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    usr_mode_t          mode;
    logic [WIDTH-1:0]   d;
    logic               sl_in;
    logic               sr_in;
    logic               start;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   q;
    logic               so_msb;
    logic               so_lsb;
    logic               busy;
    logic               done;

    modport master (
        output mode, d, sl_in, sr_in, start, count,
        input  q, so_msb, so_lsb, busy, done
    );

    modport slave (
        input  mode, d, sl_in, sr_in, start, count,
        output q, so_msb, so_lsb, busy, done
    );

endinterface

// File: rtl/universal_shift_register_dff_ar.sv
// rtl/universal_shift_register_dff_ar.sv - single-bit D flip-flop with asynchronous reset value
// Purpose : one storage bit of the shift register.
// Ports   : i_clk     rising-edge clock
//           i_rst     asynchronous active-high reset
//           i_rst_val value taken while i_rst is high
//           i_d       next value
//           o_q       stored bit
module dff_ar (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rst_val,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= i_rst_val;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - WIDTH-bit universal shift register with counted-burst engine
// Purpose : per-cycle hold/load/clear/shift/rotate/arithmetic-shift operations,
//           plus a burst engine that repeats a shift/rotate mode N times and
//           then pulses done.
// Ports   : clk    rising-edge clock
//           reset  asynchronous active-high reset
//           bus    universal_shift_register_if.slave
//                  (mode, d, sl_in, sr_in, start, count -> q, so_msb, so_lsb, busy, done)
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    universal_shift_register_if.slave     bus
);

    localparam int CW = $clog2(WIDTH + 1);

    usr_state_t             r_state;
    logic [CW-1:0]          r_cnt;
    usr_mode_t              r_mode;
    logic                   r_done;

    usr_state_t             w_state_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    usr_mode_t              w_mode_nxt;
    logic                   w_done_nxt;

    logic [WIDTH-1:0]       w_q;
    logic [WIDTH-1:0]       w_q_nxt;
    usr_mode_t              w_op_mode;
    logic [USR_MAX_W-1:0]   w_q_ext;
    logic [USR_MAX_W-1:0]   w_d_ext;
    logic [USR_MAX_W-1:0]   w_q_op;

    // Storage: one flip-flop per bit, each with its own reset value bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            dff_ar u_bit (
                .i_clk     (clk),
                .i_rst     (reset),
                .i_rst_val (RESET_VAL[gi]),
                .i_d       (w_q_nxt[gi]),
                .o_q       (w_q[gi])
            );
        end
    endgenerate

    // During a burst the latched mode drives the datapath; bus.mode is ignored.
    assign w_op_mode = (r_state == RUN) ? r_mode : bus.mode;

    always_comb begin
        w_q_ext              = '0;
        w_q_ext[WIDTH-1:0]   = w_q;
        w_d_ext              = '0;
        w_d_ext[WIDTH-1:0]   = bus.d;
    end

    assign w_q_op = next_q(w_op_mode, w_q_ext, bus.sl_in, bus.sr_in, WIDTH, w_d_ext);

    // next_q masks to WIDTH bits, so the upper bits are always zero.
    generate
        if (WIDTH < USR_MAX_W) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_q_op[USR_MAX_W-1:WIDTH];
        end
    endgenerate

    // FSM state register plus burst bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mode  <= HOLD;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state, next-q and done decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        w_q_nxt     = w_q;
        case (r_state)
            IDLE: begin
                if (!bus.start) begin
                    w_q_nxt = w_q_op[WIDTH-1:0];
                end else if (!is_burst_mode(bus.mode)) begin
                    // Hold/load/clear commands complete in a single edge.
                    w_q_nxt    = w_q_op[WIDTH-1:0];
                    w_done_nxt = 1'b1;
                end else if (bus.count == '0) begin
                    // Zero-length burst: nothing to do but acknowledge.
                    w_done_nxt = 1'b1;
                end else begin
                    // The start edge only latches; q is left untouched.
                    w_state_nxt = RUN;
                    w_cnt_nxt   = bus.count;
                    w_mode_nxt  = bus.mode;
                end
            end
            RUN: begin
                w_q_nxt   = w_q_op[WIDTH-1:0];
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = IDLE;
                    w_mode_nxt  = HOLD;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_mode_nxt  = HOLD;
            end
        endcase
    end

    assign bus.q      = w_q;
    assign bus.so_msb = w_q[WIDTH-1];
    assign bus.so_lsb = w_q[0];
    assign bus.busy   = (r_state == RUN);
    assign bus.done   = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - directed-vector bench for universal_shift_register
module tb_universal_shift_register;
    import usr_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    universal_shift_register_if #(.WIDTH(8)) bus ();

    universal_shift_register #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL rst_q got=%h exp=%h", bus.q, 8'h00); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_step();
        bus.mode = LOAD; bus.d = 8'h81; step();
        n_vec++; if (bus.q !== 8'h81) begin n_err++; $display("FAIL ss_load got=%h exp=%h", bus.q, 8'h81); end
        bus.mode = SHL; bus.sl_in = 1'b1; step();
        n_vec++; if (bus.q !== 8'h03) begin n_err++; $display("FAIL ss_shl got=%h exp=%h", bus.q, 8'h03); end
        n_vec++; if (bus.so_msb !== 1'b0) begin n_err++; $display("FAIL ss_so_msb got=%b exp=0", bus.so_msb); end
        n_vec++; if (bus.so_lsb !== 1'b1) begin n_err++; $display("FAIL ss_so_lsb got=%b exp=1", bus.so_lsb); end
        bus.mode = LOAD; bus.d = 8'h80; step();
        bus.mode = ASR; step();
        n_vec++; if (bus.q !== 8'hC0) begin n_err++; $display("FAIL ss_asr got=%h exp=%h", bus.q, 8'hC0); end
        bus.mode = SHR; bus.sr_in = 1'b0; step();
        n_vec++; if (bus.q !== 8'h60) begin n_err++; $display("FAIL ss_shr got=%h exp=%h", bus.q, 8'h60); end
        bus.mode = ROR; step(); step(); step(); step(); step(); step();
        n_vec++; if (bus.q !== 8'h81) begin n_err++; $display("FAIL ss_ror got=%h exp=%h", bus.q, 8'h81); end
        bus.mode = ROL; step();
        n_vec++; if (bus.q !== 8'h03) begin n_err++; $display("FAIL ss_rol got=%h exp=%h", bus.q, 8'h03); end
        bus.mode = HOLD; step();
        n_vec++; if (bus.q !== 8'h03) begin n_err++; $display("FAIL ss_hold got=%h exp=%h", bus.q, 8'h03); end
        bus.mode = CLEAR; step();
        n_vec++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL ss_clear got=%h exp=%h", bus.q, 8'h00); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL ss_done got=%b exp=0", bus.done); end
        bus.mode = HOLD;
    endtask

    task automatic test_burst_rotate();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h02; exp_q[1] = 8'h04; exp_q[2] = 8'h08;
        bus.mode = LOAD; bus.d = 8'h01; step();
        bus.mode = ROL; bus.count = 4'd3; bus.start = 1'b1; step();
        bus.start = 1'b0; bus.mode = HOLD;
        n_vec++; if (bus.q !== 8'h01) begin n_err++; $display("FAIL br_start_q got=%h exp=%h", bus.q, 8'h01); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL br_start_busy got=%b exp=1", bus.busy); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (bus.q !== exp_q[i]) begin n_err++; $display("FAIL br_q[%0d] got=%h exp=%h", i, bus.q, exp_q[i]); end
            n_vec++; if (bus.busy !== (i < 2)) begin n_err++; $display("FAIL br_busy[%0d] got=%b exp=%b", i, bus.busy, (i < 2)); end
            n_vec++; if (bus.done !== (i == 2)) begin n_err++; $display("FAIL br_done[%0d] got=%b exp=%b", i, bus.done, (i == 2)); end
        end
        step();
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL br_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_wrap();
        bus.mode = LOAD; bus.d = 8'h96; step();
        bus.mode = ROR; bus.count = 4'd8; bus.start = 1'b1; step();
        bus.start = 1'b0; bus.mode = HOLD;
        repeat (8) step();
        n_vec++; if (bus.q !== 8'h96) begin n_err++; $display("FAIL wr_ror8 got=%h exp=%h", bus.q, 8'h96); end
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL wr_ror8_done got=%b exp=1", bus.done); end
        bus.mode = SHR; bus.sr_in = 1'b0; bus.count = 4'd10; bus.start = 1'b1; step();
        bus.start = 1'b0; bus.mode = HOLD;
        repeat (9) step();
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL wr_shr10_busy got=%b exp=1", bus.busy); end
        step();
        n_vec++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL wr_shr10 got=%h exp=%h", bus.q, 8'h00); end
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL wr_shr10_done got=%b exp=1", bus.done); end
    endtask

    task automatic test_boundaries();
        bus.mode = LOAD; bus.d = 8'h5A; step();
        bus.mode = SHL; bus.sl_in = 1'b1; bus.count = 4'd0; bus.start = 1'b1; step();
        bus.start = 1'b0; bus.mode = HOLD;
        n_vec++; if (bus.q !== 8'h5A) begin n_err++; $display("FAIL bd_cnt0_q got=%h exp=%h", bus.q, 8'h5A); end
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL bd_cnt0_done got=%b exp=1", bus.done); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bd_cnt0_busy got=%b exp=0", bus.busy); end
        step();
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL bd_cnt0_done2 got=%b exp=0", bus.done); end
        bus.mode = LOAD; bus.d = 8'h3C; bus.count = 4'd7; bus.start = 1'b1; step();
        bus.start = 1'b0; bus.mode = HOLD;
        n_vec++; if (bus.q !== 8'h3C) begin n_err++; $display("FAIL bd_load_q got=%h exp=%h", bus.q, 8'h3C); end
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL bd_load_done got=%b exp=1", bus.done); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bd_load_busy got=%b exp=0", bus.busy); end
        step();
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h87; exp_q[1] = 8'hC3; exp_q[2] = 8'hE1; exp_q[3] = 8'hF0;
        bus.mode = LOAD; bus.d = 8'h0F; step();
        bus.mode = SHR; bus.sr_in = 1'b1; bus.count = 4'd4; bus.start = 1'b1; step();
        bus.mode = CLEAR; bus.d = 8'h00; bus.count = 4'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (bus.q !== exp_q[i]) begin n_err++; $display("FAIL ig_q[%0d] got=%h exp=%h", i, bus.q, exp_q[i]); end
            n_vec++; if (bus.done !== (i == 3)) begin n_err++; $display("FAIL ig_done[%0d] got=%b exp=%b", i, bus.done, (i == 3)); end
        end
        bus.mode = ROL; bus.count = 4'd1; step();
        bus.start = 1'b0; bus.mode = HOLD;
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
        n_vec++; if (bus.q !== 8'hF0) begin n_err++; $display("FAIL b2b_start_q got=%h exp=%h", bus.q, 8'hF0); end
        step();
        n_vec++; if (bus.q !== 8'hE1) begin n_err++; $display("FAIL b2b_q got=%h exp=%h", bus.q, 8'hE1); end
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_done got=%b exp=1", bus.done); end
        step();
    endtask

    task automatic test_reset_mid_burst();
        bus.mode = LOAD; bus.d = 8'hA5; step();
        bus.mode = ROL; bus.count = 4'd5; bus.start = 1'b1; step();
        bus.start = 1'b0; bus.mode = HOLD;
        step();
        n_vec++; if (bus.q !== 8'h4B) begin n_err++; $display("FAIL rm_op1 got=%h exp=%h", bus.q, 8'h4B); end
        step();
        n_vec++; if (bus.q !== 8'h96) begin n_err++; $display("FAIL rm_op2 got=%h exp=%h", bus.q, 8'h96); end
        reset = 1'b1;
        #1;
        n_vec++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL rm_async_q got=%h exp=%h", bus.q, 8'h00); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rm_async_busy got=%b exp=0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rm_async_done got=%b exp=0", bus.done); end
        step();
        reset = 1'b0;
        step();
        step();
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rm_after_busy got=%b exp=0", bus.busy); end
        n_vec++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL rm_after_q got=%h exp=%h", bus.q, 8'h00); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rm_after_done got=%b exp=0", bus.done); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.mode  = HOLD;
        bus.d     = 8'h00;
        bus.sl_in = 1'b0;
        bus.sr_in = 1'b0;
        bus.start = 1'b0;
        bus.count = 4'd0;
        test_reset();
        test_single_step();
        test_burst_rotate();
        test_wrap();
        test_boundaries();
        test_ignored_inputs();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the single-bit edge-triggered storage element. A WIDTH-bit register with asynchronous reset, per-cycle operating modes (hold, load, clear, shift, rotate, arithmetic shift right) and a counted-burst engine.
- The burst engine applies a shift/rotate mode for N consecutive cycles, then pulses done.
- Serves as the storage/datapath workhorse for later labs (serial links, multipliers, LED patterns).

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RESET_VAL, '0, value loaded into q on reset.
- CW (localparam), $clog2(WIDTH+1), width of the burst count port.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  3  operation select (usr_mode_t).
- d  input  WIDTH  parallel load data.
- sl_in  input  1  serial bit shifted into bit 0 on SHL.
- sr_in  input  1  serial bit shifted into bit WIDTH-1 on SHR.
- start  input  1  begin burst using mode/count sampled this edge.
- count  input  CW  burst length N (number of operations).
- q  output  WIDTH  register contents.
- so_msb  output  1  q[WIDTH-1], combinational.
- so_lsb  output  1  q[0], combinational.
- busy  output  1  high while burst in RUN.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, any time, including mid-burst):
  - q=RESET_VAL, busy=0, done=0, state=IDLE.
  - Internal count and latched mode are cleared.
- Mode encodings and operations:
  - HOLD=0: q unchanged.
  - LOAD=1: q=d.
  - CLEAR=2: q=0.
  - SHL=3: q={q[W-2:0],sl_in}.
  - SHR=4: q={sr_in,q[W-1:1]}.
  - ROL=5: q={q[W-2:0],q[W-1]}.
  - ROR=6: q={q[0],q[W-1:1]}.
  - ASR=7: q={q[W-1],q[W-1:1]}.
- IDLE, start=0: mode is applied at every rising edge (single-step operation); done=0.
- IDLE, start=1, mode in HOLD/LOAD/CLEAR:
  - The op is applied once at this edge and count is ignored.
  - done=1 for the following cycle; stays IDLE.
- IDLE, start=1, mode in SHL..ASR, count=0: q unchanged; done=1 next cycle; stays IDLE.
- IDLE, start=1, mode in SHL..ASR, count=N>0:
  - This edge latches mode and N, does not modify q, sets busy=1 and moves to RUN.
- RUN:
  - Each edge applies the latched mode once and decrements the remaining count.
  - sl_in/sr_in are sampled live every edge.
  - The edge performing the Nth op sets busy=0 and done=1, and returns to IDLE.
  - Total: start edge plus N op edges; done is high in the cycle after the start edge + N.
- RUN ignores mode, d, start and count; a start asserted during RUN is dropped, not queued.
- done is never high for two consecutive cycles unless two back-to-back start commands complete that way.
- Back-to-back: start may be asserted in the done cycle and is accepted normally.
- Count widths: count is unsigned; values above WIDTH are legal (rotates wrap naturally, shifts fill entirely with serial input).
- No X propagation: all state has a reset value.

Decomposition:
- Package usr_pkg holds:
  - typedef enum logic [2:0] usr_mode_t (HOLD..ASR);
  - typedef enum logic usr_state_t {IDLE, RUN};
  - a function next_q(mode, q, sl_in, sr_in), shared with the testbench model.
- Sub-module dff_ar: a 1-bit D flip-flop with async active-high reset and a reset-value input, instantiated WIDTH times via generate.
- The top level contains the next-state mux, the FSM and the down-counter.

Test Plan:
- Reset mid-burst: LOAD 0xA5, start ROL count=5, assert reset after 2 ops -> q=RESET_VAL (0x00) immediately (before next edge), busy=0, done=0.
- Single-step: LOAD 0x81, then SHL with sl_in=1 for 1 cycle -> q=0x03, so_msb=0; then ASR on 0x80 -> 0xC0.
- Burst rotate: q=0x01, start ROL count=3 -> busy high 3 cycles; q=0x02,0x04,0x08; done pulses 1 cycle with q=0x08.
- Wrap-around: q=0x96, start ROR count=8 -> q=0x96 at done; count=10 with SHR, sr_in=0 -> q=0x00.
- Boundaries: start SHL count=0 -> q unchanged, done next cycle, busy never high; start LOAD d=0x3C count=7 -> q=0x3C, done next cycle.
- Ignored inputs: during RUN, toggle mode=CLEAR and start=1 -> no effect; burst finishes with the latched mode; a new start in the done cycle is accepted.
